// File: rtl/sram_port_arbiter.sv
// Purpose : shares one SRAM a/b port between the calculator controller (port 0)
//           and the host load/readback path (port 1) with round-robin arbitration.
// Latency : command on the SRAM pins 1 cycle after grant; read data 2 cycles after grant.
// Backpressure: a requester holds req/we/addr/wdata until it sees its gnt. At most one
//           grant per cycle. Optional burst lock is built with ARB_LOCK_EN.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   reqN_i/weN_i/addrN_i/wdataN_i  command from requester N (0 = controller, 1 = host)
//   lockN_i                    burst lock request (ARB_LOCK_EN only)
//   gntN_o                     combinational accept for requester N
//   rvalidN_o/rdataN_o         read return to requester N (rdata is 0 when rvalid is low)
//   sram_*_o                   registered SRAM command; wdata_a = word[31:0], wdata_b = upper bits
//   sram_rdata_a_i/b_i         SRAM read data, valid 1 cycle after the command is on the pins

package calculator_pkg;
  localparam int ADDR_W        = 10;
  localparam int MEM_WORD_SIZE = 64;
endpackage

module sram_port_arbiter #(
  parameter int ADDR_W        = calculator_pkg::ADDR_W,
  parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE
`ifdef ARB_LOCK_EN
  ,
  parameter int LOCK_MAX      = 8
`endif
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req0_i,
  input  logic                        we0_i,
  input  logic [ADDR_W-1:0]           addr0_i,
  input  logic [MEM_WORD_SIZE-1:0]    wdata0_i,
  input  logic                        req1_i,
  input  logic                        we1_i,
  input  logic [ADDR_W-1:0]           addr1_i,
  input  logic [MEM_WORD_SIZE-1:0]    wdata1_i,
`ifdef ARB_LOCK_EN
  input  logic                        lock0_i,
  input  logic                        lock1_i,
`endif
  output logic                        gnt0_o,
  output logic                        gnt1_o,
  output logic                        rvalid0_o,
  output logic                        rvalid1_o,
  output logic [MEM_WORD_SIZE-1:0]    rdata0_o,
  output logic [MEM_WORD_SIZE-1:0]    rdata1_o,
  output logic                        sram_csb_o,
  output logic                        sram_web_o,
  output logic [ADDR_W-1:0]           sram_addr_o,
  output logic [31:0]                 sram_wdata_a_o,
  output logic [MEM_WORD_SIZE-33:0]   sram_wdata_b_o,
  input  logic [31:0]                 sram_rdata_a_i,
  input  logic [MEM_WORD_SIZE-33:0]   sram_rdata_b_i
);

  // last_q: index of the most recent winner; reset to 1 so port 0 wins first contention.
  logic last_q;
  logic gnt0, gnt1, any_gnt;
  logic sel_we;
  logic [ADDR_W-1:0]        sel_addr;
  logic [MEM_WORD_SIZE-1:0] sel_wdata;

  // Read tag pipe: stage 1 lines up with the command on the pins, stage 2 with the
  // SRAM read data.
  logic tag1_vld_q, tag1_id_q, tag2_vld_q, tag2_id_q;

`ifdef ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  // cnt_q counts consecutive locked grants to the port in last_q; nonzero means that
  // port holds a lock from the previous cycle.
  logic [CNT_W-1:0] cnt_q;
  logic owner_keeps, other_req, cnt_sat, lock_hold, sel_lock;

  assign owner_keeps = last_q ? (req1_i & lock1_i) : (req0_i & lock0_i);
  assign other_req   = last_q ? req0_i : req1_i;
  assign cnt_sat     = (cnt_q == CNT_W'(LOCK_MAX));
  // After LOCK_MAX locked grants the lock only yields if the other port is asking.
  assign lock_hold   = (cnt_q != '0) & owner_keeps & ~(cnt_sat & other_req);
  assign sel_lock    = gnt1 ? lock1_i : lock0_i;
`endif

  always_comb begin
    // Round-robin: a lone requester always wins; on contention the non-last port wins.
    gnt0 = req0_i & (~req1_i | last_q);
    gnt1 = req1_i & (~req0_i | ~last_q);
`ifdef ARB_LOCK_EN
    if (lock_hold) begin
      gnt0 = ~last_q;
      gnt1 = last_q;
    end
`endif
    if (rst_i) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    any_gnt   = gnt0 | gnt1;
    sel_we    = gnt1 ? we1_i    : we0_i;
    sel_addr  = gnt1 ? addr1_i  : addr0_i;
    sel_wdata = gnt1 ? wdata1_i : wdata0_i;
  end

  assign gnt0_o = gnt0;
  assign gnt1_o = gnt1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q         <= 1'b1;
      sram_csb_o     <= 1'b1;
      sram_web_o     <= 1'b1;
      sram_addr_o    <= '0;
      sram_wdata_a_o <= '0;
      sram_wdata_b_o <= '0;
      tag1_vld_q     <= 1'b0;
      tag1_id_q      <= 1'b0;
      tag2_vld_q     <= 1'b0;
      tag2_id_q      <= 1'b0;
    end else begin
      if (any_gnt) begin
        last_q         <= gnt1;
        sram_csb_o     <= 1'b0;
        sram_web_o     <= ~sel_we;
        sram_addr_o    <= sel_addr;
        sram_wdata_a_o <= sel_wdata[31:0];
        sram_wdata_b_o <= sel_wdata[MEM_WORD_SIZE-1:32];
      end else begin
        // Idle cycle: deselect, but leave address/data pins where they were.
        sram_csb_o <= 1'b1;
        sram_web_o <= 1'b1;
      end
      tag1_vld_q <= any_gnt & ~sel_we;
      tag1_id_q  <= gnt1;
      tag2_vld_q <= tag1_vld_q;
      tag2_id_q  <= tag1_id_q;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (any_gnt && sel_lock) begin
      if ((cnt_q != '0) && (gnt1 == last_q)) begin
        cnt_q <= cnt_sat ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end
`endif

  // Gating with rst_i keeps the returns quiet while reset is held, before the
  // tag pipe has been cleared by the first reset edge.
  assign rvalid0_o = tag2_vld_q & ~tag2_id_q & ~rst_i;
  assign rvalid1_o = tag2_vld_q &  tag2_id_q & ~rst_i;
  assign rdata0_o  = rvalid0_o ? {sram_rdata_b_i, sram_rdata_a_i} : '0;
  assign rdata1_o  = rvalid1_o ? {sram_rdata_b_i, sram_rdata_a_i} : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 64;
`ifdef ARB_LOCK_EN
  localparam int LOCK_MAX = 4;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic req0_i = 0, we0_i = 0, req1_i = 0, we1_i = 0;
  logic [AW-1:0] addr0_i = '0, addr1_i = '0;
  logic [DW-1:0] wdata0_i = '0, wdata1_i = '0;
`ifdef ARB_LOCK_EN
  logic lock0_i = 0, lock1_i = 0;
`endif
  logic gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
  logic [DW-1:0] rdata0_o, rdata1_o;
  logic sram_csb_o, sram_web_o;
  logic [AW-1:0] sram_addr_o;
  logic [31:0] sram_wdata_a_o, sram_wdata_b_o, sram_rdata_a_i, sram_rdata_b_i;

  always #5 clk_i = ~clk_i;

  sram_port_arbiter #(
    .ADDR_W(AW), .MEM_WORD_SIZE(DW)
`ifdef ARB_LOCK_EN
    , .LOCK_MAX(LOCK_MAX)
`endif
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
    .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
`ifdef ARB_LOCK_EN
    .lock0_i(lock0_i), .lock1_i(lock1_i),
`endif
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
    .rvalid0_o(rvalid0_o), .rvalid1_o(rvalid1_o),
    .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
    .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_a_o(sram_wdata_a_o), .sram_wdata_b_o(sram_wdata_b_o),
    .sram_rdata_a_i(sram_rdata_a_i), .sram_rdata_b_i(sram_rdata_b_i)
  );

  // Behavioural SRAM macro: one-cycle read latency, synchronous write.
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] sram_rd = '0;
  always @(posedge clk_i) begin
    if (!sram_csb_o) begin
      if (!sram_web_o) sram_mem[sram_addr_o] <= {sram_wdata_b_o, sram_wdata_a_o};
      else             sram_rd <= sram_mem[sram_addr_o];
    end
  end
  assign sram_rdata_a_i = sram_rd[31:0];
  assign sram_rdata_b_i = sram_rd[63:32];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model state: memory contents in grant order, contention preference,
  // lock run length and owner.
  typedef struct { int due; logic csb; logic web; logic [AW-1:0] addr; logic [31:0] wa; logic [31:0] wb; } pin_t;
  typedef struct { int due; logic [DW-1:0] data; } rd_t;
  pin_t pinq[$];
  rd_t  rq[2][$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int pref = 0;
  int lrun = 0;
  int lown = 0;
  logic [AW-1:0] hold_addr = '0;
  logic [DW-1:0] hold_wd = '0;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
  end

  // Predictor: expected grant from the requests, expected pin state next cycle,
  // expected read data two cycles out.
  int pw;
  logic p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wd;
  logic p_lk;
  pin_t pe;
  rd_t re;
  always @(negedge clk_i) begin
    if (rst_i) begin
      chk("gnt0_in_reset", gnt0_o, 0);
      chk("gnt1_in_reset", gnt1_o, 0);
      rq[0].delete();
      rq[1].delete();
      pref = 0; lrun = 0; lown = 0;
      hold_addr = '0; hold_wd = '0;
      pe.due = cyc + 1; pe.csb = 1; pe.web = 1; pe.addr = '0; pe.wa = '0; pe.wb = '0;
      pinq.push_back(pe);
    end else begin
      pw = -1;
      if (req0_i && req1_i) begin
        pw = pref;
`ifdef ARB_LOCK_EN
        if (lrun > 0 && (lown == 0 ? lock0_i : lock1_i) && lrun < LOCK_MAX) pw = lown;
`endif
      end else if (req0_i) pw = 0;
      else if (req1_i) pw = 1;
      chk("gnt0", gnt0_o, (pw == 0));
      chk("gnt1", gnt1_o, (pw == 1));
      if (pw >= 0) begin
        p_we   = (pw == 1) ? we1_i : we0_i;
        p_addr = (pw == 1) ? addr1_i : addr0_i;
        p_wd   = (pw == 1) ? wdata1_i : wdata0_i;
        p_lk   = 0;
`ifdef ARB_LOCK_EN
        p_lk   = (pw == 1) ? lock1_i : lock0_i;
`endif
        pe.due = cyc + 1; pe.csb = 0; pe.web = ~p_we; pe.addr = p_addr;
        pe.wa = p_wd[31:0]; pe.wb = p_wd[63:32];
        pinq.push_back(pe);
        hold_addr = p_addr; hold_wd = p_wd;
        if (p_we) ref_mem[p_addr] = p_wd;
        else begin
          re.due = cyc + 2; re.data = ref_mem[p_addr];
          rq[pw].push_back(re);
        end
        pref = 1 - pw;
        if (p_lk) begin
          lrun = (lrun > 0 && lown == pw) ? lrun + 1 : 1;
`ifdef ARB_LOCK_EN
          if (lrun > LOCK_MAX) lrun = LOCK_MAX;
`endif
          lown = pw;
        end else lrun = 0;
      end else begin
        pe.due = cyc + 1; pe.csb = 1; pe.web = 1; pe.addr = hold_addr;
        pe.wa = hold_wd[31:0]; pe.wb = hold_wd[63:32];
        pinq.push_back(pe);
        lrun = 0;
      end
    end
  end

  // Monitor: pops expectations whenever their cycle comes up.
  pin_t me;
  rd_t  mr;
  logic mv, mev;
  logic [DW-1:0] md;
  always @(negedge clk_i) begin
    if (pinq.size() > 0 && pinq[0].due == cyc) begin
      me = pinq.pop_front();
      chk("sram_csb", sram_csb_o, me.csb);
      chk("sram_web", sram_web_o, me.web);
      chk("sram_addr", sram_addr_o, me.addr);
      chk("sram_wdata_a", sram_wdata_a_o, me.wa);
      chk("sram_wdata_b", sram_wdata_b_o, me.wb);
    end
    if (rst_i) begin
      chk("rvalid0_in_reset", rvalid0_o, 0);
      chk("rvalid1_in_reset", rvalid1_o, 0);
      chk("rdata0_in_reset", rdata0_o, 0);
      chk("rdata1_in_reset", rdata1_o, 0);
    end else begin
      for (int p = 0; p < 2; p++) begin
        mv = (p == 1) ? rvalid1_o : rvalid0_o;
        md = (p == 1) ? rdata1_o : rdata0_o;
        while (rq[p].size() > 0 && rq[p][0].due < cyc) begin
          chk("rvalid_overdue", 0, 1);
          void'(rq[p].pop_front());
        end
        mev = (rq[p].size() > 0 && rq[p][0].due == cyc);
        chk(p ? "rvalid1" : "rvalid0", mv, mev);
        if (mev) begin
          mr = rq[p].pop_front();
          chk(p ? "rdata1" : "rdata0", md, mr.data);
        end else begin
          chk(p ? "rdata1_idle" : "rdata0_idle", md, 0);
        end
      end
    end
  end

  // Stimulus helpers. gs0/gs1 remember whether the last cycle's request was taken.
  logic gs0 = 0, gs1 = 0;
  logic [1:0] glog[$];

  task automatic run(int n, int p0, int p1, int pwr, int pl0, int pl1);
    for (int c = 0; c < n; c++) begin
      @(posedge clk_i); #1;
      if (!req0_i || gs0) begin
        req0_i = ($urandom_range(99) < p0);
        we0_i = ($urandom_range(99) < pwr);
        addr0_i = AW'($urandom_range(7));
        wdata0_i = {$urandom, $urandom};
`ifdef ARB_LOCK_EN
        lock0_i = ($urandom_range(99) < pl0);
`endif
      end
      if (!req1_i || gs1) begin
        req1_i = ($urandom_range(99) < p1);
        we1_i = ($urandom_range(99) < pwr);
        addr1_i = AW'($urandom_range(7));
        wdata1_i = {$urandom, $urandom};
`ifdef ARB_LOCK_EN
        lock1_i = ($urandom_range(99) < pl1);
`endif
      end
      @(negedge clk_i);
      gs0 = gnt0_o; gs1 = gnt1_o;
      glog.push_back({gnt1_o, gnt0_o});
    end
  endtask

  task automatic clear_inputs();
    req0_i = 0; req1_i = 0; we0_i = 0; we1_i = 0;
`ifdef ARB_LOCK_EN
    lock0_i = 0; lock1_i = 0;
`endif
    gs0 = 0; gs1 = 0;
  endtask

  task automatic do_reset(int n);
    @(posedge clk_i); #1;
    rst_i = 1;
    clear_inputs();
    repeat (n) @(posedge clk_i);
    #1 rst_i = 0;
  endtask

  // Drives one command on port p, waits (bounded) for its grant, then drops req.
  task automatic issue(int p, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    bit got;
    @(posedge clk_i); #1;
    clear_inputs();
    if (p == 0) begin req0_i = 1; we0_i = we; addr0_i = a; wdata0_i = d; end
    else        begin req1_i = 1; we1_i = we; addr1_i = a; wdata1_i = d; end
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk_i);
      got = (p == 0) ? gnt0_o : gnt1_o;
    end
    chk("issue_grant_timeout", got, 1);
    @(posedge clk_i); #1;
    clear_inputs();
  endtask

  int seen;
  logic [1:0] exp_seq [6];
  initial begin
    // Reset check with both ports requesting: outputs must sit at reset values.
    clear_inputs();
    req0_i = 1; req1_i = 1;
    @(posedge clk_i); @(negedge clk_i);
    chk("rst_gnt0", gnt0_o, 0);
    chk("rst_gnt1", gnt1_o, 0);
    chk("rst_rvalid0", rvalid0_o, 0);
    chk("rst_rvalid1", rvalid1_o, 0);
    chk("rst_rdata0", rdata0_o, 0);
    chk("rst_rdata1", rdata1_o, 0);
    chk("rst_csb", sram_csb_o, 1);
    chk("rst_web", sram_web_o, 1);
    chk("rst_addr", sram_addr_o, 0);
    chk("rst_wdata_a", sram_wdata_a_o, 0);
    chk("rst_wdata_b", sram_wdata_b_o, 0);
    @(posedge clk_i); #1;
    rst_i = 0;
    clear_inputs();

    // Port 0 alone: write then read back address 5.
    issue(0, 1, AW'(5), 64'h0000_0002_0000_0001);
    @(negedge clk_i);
    chk("wr_pins_wdata_a", sram_wdata_a_o, 32'h1);
    chk("wr_pins_wdata_b", sram_wdata_b_o, 32'h2);
    issue(0, 0, AW'(5), '0);
    @(negedge clk_i); @(negedge clk_i);
    chk("rd_rvalid0", rvalid0_o, 1);
    chk("rd_rdata0", rdata0_o, 64'h0000_0002_0000_0001);

    // Contention right after reset: grants alternate starting with port 0.
    do_reset(2);
    glog.delete();
    run(6, 100, 100, 0, 0, 0);
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 6; i++) chk("contention_seq", glog[i], exp_seq[i]);
    @(posedge clk_i); #1;
    clear_inputs();
    repeat (3) @(negedge clk_i);

    // Reset while a port 1 read is in flight: that read must never return.
    issue(1, 0, AW'(5), '0);
    rst_i = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (rvalid1_o) seen++;
      if (i == 1) begin
        @(posedge clk_i); #1 rst_i = 0;
      end
    end
    chk("mid_read_reset_rvalid1", seen, 0);

`ifdef ARB_LOCK_EN
    // Locked port 1 keeps the port for LOCK_MAX grants, then port 0 gets one.
    do_reset(2);
    glog.delete();
    run(1, 0, 100, 0, 0, 100);
    run(4, 100, 100, 0, 0, 100);
    for (int i = 0; i < 4; i++) chk("lock_p1_hold", glog[i], 2'b10);
    chk("lock_handoff_p0", glog[4], 2'b01);
    @(posedge clk_i); #1;
    clear_inputs();
    repeat (3) @(negedge clk_i);

    // Locked lone requester: no forced gap after LOCK_MAX.
    do_reset(2);
    glog.delete();
    run(10, 100, 0, 0, 100, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) if (glog[i] == 2'b01) seen++;
    chk("lock_alone_grants", seen, 10);
    @(posedge clk_i); #1;
    clear_inputs();
    repeat (3) @(negedge clk_i);
`endif

    // Randomised traffic against the reference model, light then saturated.
    do_reset(2);
    run(300, 60, 60, 50, 40, 40);
    run(150, 100, 100, 50, 70, 70);
    run(20, 0, 0, 50, 0, 0);
    @(posedge clk_i); #1;
    clear_inputs();
    repeat (4) @(negedge clk_i);
    chk("drain_rq0_empty", rq[0].size(), 0);
    chk("drain_rq1_empty", rq[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
